// File: rtl/fifo_pkg.sv
// Shared defaults for the synchronous FIFO: entry width, pointer width,
// derived depth, and an encoding of the per-edge push/pop request pair.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int FIFO_DEPTH      = 1 << FIFO_ADDR_WIDTH;

    // {wr, rd} as seen on a clock edge
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fifo_ctrl.sv
// Pointer and flag control for the synchronous FIFO. Owns the read/write
// pointers and the registered full/empty flags; the storage lives in the top.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic                  rd,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  full,
    output logic                  empty
);

    logic [ADDR_WIDTH-1:0] wr_ptr_reg;
    logic [ADDR_WIDTH-1:0] rd_ptr_reg;
    logic                  full_reg;
    logic                  empty_reg;
    logic [ADDR_WIDTH-1:0] wr_ptr_next;
    logic [ADDR_WIDTH-1:0] rd_ptr_next;
    fifo_op_e              op;

    // Pointers wrap naturally because they are exactly ADDR_WIDTH bits wide.
    assign wr_ptr_next = wr_ptr_reg + ADDR_WIDTH'(1);
    assign rd_ptr_next = rd_ptr_reg + ADDR_WIDTH'(1);
    assign op          = fifo_op_e'({wr, rd});

    // A write into storage happens exactly when a push is accepted; when full
    // a simultaneous push/pop degrades to a pop, so the new data is not stored.
    assign wr_en   = wr & ~full_reg;
    assign wr_addr = wr_ptr_reg;
    assign rd_addr = rd_ptr_reg;
    assign full    = full_reg;
    assign empty   = empty_reg;

    // Advance pointers and update flags on the edge that accepts push/pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            case (op)
                OP_PUSH: begin
                    if (!full_reg) begin
                        wr_ptr_reg <= wr_ptr_next;
                        empty_reg  <= 1'b0;
                        full_reg   <= (wr_ptr_next == rd_ptr_reg);
                    end
                end
                OP_POP: begin
                    if (!empty_reg) begin
                        rd_ptr_reg <= rd_ptr_next;
                        full_reg   <= 1'b0;
                        empty_reg  <= (rd_ptr_next == wr_ptr_reg);
                    end
                end
                OP_BOTH: begin
                    if (empty_reg) begin
                        // Nothing to pop yet: behaves as a push.
                        wr_ptr_reg <= wr_ptr_next;
                        empty_reg  <= 1'b0;
                    end else if (full_reg) begin
                        // No room for the push: behaves as a pop.
                        rd_ptr_reg <= rd_ptr_next;
                        full_reg   <= 1'b0;
                    end else begin
                        // Occupancy unchanged, so the flags hold.
                        wr_ptr_reg <= wr_ptr_next;
                        rd_ptr_reg <= rd_ptr_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head entry is always
// presented combinationally on r_Data; it is meaningful only while empty = 0.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [DATA_WIDTH-1:0] w_Data,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] r_Data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;

    // Storage is deliberately not reset; stale entries are unreachable
    // while empty is set.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    fifo_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ctrl (
        .clk     (clk),
        .rst     (rst),
        .wr      (wr),
        .rd      (rd),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .rd_addr (rd_addr),
        .full    (full),
        .empty   (empty)
    );

    // Store the incoming byte at the tail when a push is accepted.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= w_Data;
        end
    end

    // Fall-through read: the head slot is visible without a pop strobe.
    assign r_Data = mem[rd_addr];

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: a short table of vectors with fixed
// expectations, then multi-cycle sequences checked against a queue model.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr;
    logic       rd;
    logic [7:0] w_Data;
    logic       full;
    logic       empty;
    logic [7:0] r_Data;

    int total = 0;
    int bad   = 0;

    logic [7:0] model_q [$];

    sync_fifo dut (
        .clk    (clk),
        .rst    (rst),
        .wr     (wr),
        .rd     (rd),
        .w_Data (w_Data),
        .full   (full),
        .empty  (empty),
        .r_Data (r_Data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] din;
        logic       exp_full;
        logic       exp_empty;
        logic       head_valid;
        logic [7:0] exp_head;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock with scoreboard bookkeeping: the head is compared before
    // the edge, the flags after it.
    task automatic do_cycle(input logic w, input logic r, input logic [7:0] d, input string tag);
        bit pop_ok;
        bit push_ok;
        @(negedge clk);
        wr = w;
        rd = r;
        w_Data = d;
        #1;
        if (model_q.size() > 0) check({tag, "_head"}, r_Data, model_q[0]);
        pop_ok  = r && (model_q.size() > 0);
        push_ok = w && (model_q.size() < 16);
        if (pop_ok) void'(model_q.pop_front());
        if (push_ok) model_q.push_back(d);
        @(posedge clk);
        #1;
        check({tag, "_full"},  {7'd0, full},  {7'd0, model_q.size() == 16});
        check({tag, "_empty"}, {7'd0, empty}, {7'd0, model_q.size() == 0});
        $display("cycle %s wr=%0b rd=%0b din=%0h full=%0b empty=%0b count=%0d",
                 tag, w, r, d, full, empty, model_q.size());
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b0;
        wr  = 1'b0;
        rd  = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        model_q.delete();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b0;
        wr     = 1'b0;
        rd     = 1'b0;
        w_Data = 8'h00;

        //          wr    rd    din    full  empty valid head
        vecs[0] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00}; // pop on empty ignored
        vecs[1] = '{1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5}; // first push falls through
        vecs[2] = '{1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5};
        vecs[3] = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 8'h3C}; // push+pop mid-fill
        vecs[4] = '{1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h3C};
        vecs[5] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h77};
        vecs[6] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[7] = '{1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A}; // push+pop on empty = push
        vecs[8] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};

        // Reset held for two cycles
        do_reset(2);
        #1;
        check("reset_empty", {7'd0, empty}, 8'd1);
        check("reset_full",  {7'd0, full},  8'd0);

        // Table vectors
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            wr     = vecs[i].wr;
            rd     = vecs[i].rd;
            w_Data = vecs[i].din;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_full", i),  {7'd0, full},  {7'd0, vecs[i].exp_full});
            check($sformatf("vec%0d_empty", i), {7'd0, empty}, {7'd0, vecs[i].exp_empty});
            if (vecs[i].head_valid) check($sformatf("vec%0d_head", i), r_Data, vecs[i].exp_head);
            $display("vec %0d wr=%0b rd=%0b din=%0h full=%0b empty=%0b r_Data=%0h",
                     i, wr, rd, w_Data, full, empty, r_Data);
        end

        // Fill with 0..16: full rises on 15, 16 is dropped
        do_reset(2);
        for (int i = 0; i <= 16; i++) do_cycle(1'b1, 1'b0, 8'(i), $sformatf("fill%0d", i));
        check("fill_head_zero", r_Data, 8'h00);

        // Drain 17 times: 0..15 in order, 17th pop ignored
        for (int i = 0; i < 17; i++) do_cycle(1'b0, 1'b1, 8'h00, $sformatf("drain%0d", i));

        // Pointers wrapped back together: next push lands on the head
        do_cycle(1'b1, 1'b0, 8'hC3, "post_wrap_push");
        check("post_wrap_head", r_Data, 8'hC3);
        do_cycle(1'b0, 1'b1, 8'h00, "post_wrap_pop");

        // Simultaneous push/pop from empty: r_Data lags w_Data by one cycle
        for (int i = 0; i < 20; i++) begin
            do_cycle(1'b1, 1'b1, 8'(i), $sformatf("sim%0d", i));
            check($sformatf("sim%0d_lag", i), r_Data, 8'(i));
        end
        do_cycle(1'b0, 1'b1, 8'h00, "sim_final_pop");
        check("sim_final_empty", {7'd0, empty}, 8'd1);

        // Simultaneous push/pop when full degrades to a pop; EE not stored
        for (int i = 0; i < 16; i++) do_cycle(1'b1, 1'b0, 8'(8'h40 + i), $sformatf("f2_%0d", i));
        check("full_before_both", {7'd0, full}, 8'd1);
        do_cycle(1'b1, 1'b1, 8'hEE, "full_both");
        check("full_after_both", {7'd0, full}, 8'd0);
        for (int i = 0; i < 15; i++) do_cycle(1'b0, 1'b1, 8'h00, $sformatf("f2drain%0d", i));
        check("f2_empty", {7'd0, empty}, 8'd1);

        // Wrap-around across the 15 -> 0 slot boundary
        do_reset(1);
        for (int i = 0; i < 10; i++) do_cycle(1'b1, 1'b0, 8'(8'h90 + i), $sformatf("wpush%0d", i));
        for (int i = 0; i < 10; i++) do_cycle(1'b0, 1'b1, 8'h00, $sformatf("wpop%0d", i));
        for (int i = 0; i < 12; i++) do_cycle(1'b1, 1'b0, 8'(8'hB0 + i), $sformatf("wpush2_%0d", i));
        check("wrap_full",  {7'd0, full},  8'd0);
        check("wrap_empty", {7'd0, empty}, 8'd0);
        for (int i = 0; i < 12; i++) do_cycle(1'b0, 1'b1, 8'h00, $sformatf("wpop2_%0d", i));

        // Reset taken mid-operation discards contents
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, 8'(8'h20 + i), $sformatf("mid%0d", i));
        do_reset(1);
        #1;
        check("midreset_empty", {7'd0, empty}, 8'd1);
        check("midreset_full",  {7'd0, full},  8'd0);
        do_cycle(1'b1, 1'b0, 8'h6D, "after_mid_push");
        check("after_mid_head", r_Data, 8'h6D);
        do_cycle(1'b0, 1'b1, 8'h00, "after_mid_pop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
